uart_umi_host: RTL



---
 rtl/uart_umi_host.sv | 266 ++++++++++++++++++++++++++
 1 files changed

// File: rtl/uart_umi_host.sv
// UART-to-UMI initiator bridge: 8N1 command frames in, one 32-bit UMI read/write per frame, reply bytes out.
// Optional inter-byte timeout while collecting a frame: define UART_UMI_HOST_TIMEOUT_EN.
module uart_umi_host #(
   parameter int            BAUDRATE     = 115200,
   parameter int            CLK_FREQ     = 100000000,
   parameter int            DW           = 256,
   parameter int            AW           = 64,
   parameter int            CW           = 32,
   parameter logic [AW-1:0] SRCADDR      = '0,
   parameter int            TIMEOUT_BITS = 32
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          rx_pad,
   output logic          tx_pad,
   input  logic          umi_req_ready,
   output logic          umi_req_valid,
   output logic [CW-1:0] umi_req_cmd,
   output logic [AW-1:0] umi_req_dstaddr,
   output logic [AW-1:0] umi_req_srcaddr,
   output logic [DW-1:0] umi_req_data,
   output logic          umi_resp_ready,
   input  logic          umi_resp_valid,
   input  logic [CW-1:0] umi_resp_cmd,
   input  logic [DW-1:0] umi_resp_data,
   input  logic [AW-1:0] umi_resp_dstaddr,
   input  logic [AW-1:0] umi_resp_srcaddr,
   output logic [2:0]    o_dbg_state
);

   localparam int BIT_CYCLES = CLK_FREQ / BAUDRATE;
   localparam int CNT_W      = $clog2(BIT_CYCLES);
   localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(BIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(BIT_CYCLES / 2 - 1);

   localparam logic [7:0] CH_W = 8'h57;
   localparam logic [7:0] CH_R = 8'h52;
   localparam logic [CW-1:0] CMD_WR = CW'(8'h43);
   localparam logic [CW-1:0] CMD_RD = CW'(8'h41);

   typedef enum logic [2:0] {
      S_IDLE = 3'd0,
      S_ADDR = 3'd1,
      S_DATA = 3'd2,
      S_REQ  = 3'd3,
      S_WAIT = 3'd4,
      S_SEND = 3'd5
   } state_t;

   typedef enum logic [1:0] {
      RX_IDLE,
      RX_START,
      RX_DATA,
      RX_STOP
   } rx_state_t;

   // ---------------- UART receiver ----------------
   logic [1:0]       r_rx_sync;
   logic             r_rx_prev;
   rx_state_t        r_rx_state, w_rx_next;
   logic [CNT_W-1:0] r_rx_cnt;
   logic [2:0]       r_rx_bit;
   logic [7:0]       r_rx_shift;
   logic             r_rx_valid;
   logic             w_rx, w_rx_tick, w_rx_half;

   assign w_rx      = r_rx_sync[1];
   assign w_rx_tick = (r_rx_cnt == BIT_LAST);
   assign w_rx_half = (r_rx_cnt == HALF_LAST);

   always_comb begin
      w_rx_next = r_rx_state;
      case (r_rx_state)
         RX_IDLE:  if (r_rx_prev && !w_rx) w_rx_next = RX_START;
         RX_START: if (w_rx_half) w_rx_next = w_rx ? RX_IDLE : RX_DATA;
         RX_DATA:  if (w_rx_tick && r_rx_bit == 3'd7) w_rx_next = RX_STOP;
         RX_STOP:  if (w_rx_tick) w_rx_next = RX_IDLE;
         default:  w_rx_next = RX_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_rx_sync  <= 2'b11;
         r_rx_prev  <= 1'b1;
         r_rx_state <= RX_IDLE;
         r_rx_cnt   <= '0;
         r_rx_bit   <= '0;
         r_rx_shift <= '0;
         r_rx_valid <= 1'b0;
      end else begin
         r_rx_sync  <= {r_rx_sync[0], rx_pad};
         r_rx_prev  <= w_rx;
         r_rx_state <= w_rx_next;
         // A bad stop bit simply never raises the byte strobe.
         r_rx_valid <= (r_rx_state == RX_STOP) && w_rx_tick && w_rx;
         if (r_rx_state == RX_IDLE || w_rx_tick || (r_rx_state == RX_START && w_rx_half))
            r_rx_cnt <= '0;
         else
            r_rx_cnt <= r_rx_cnt + 1'b1;
         if (r_rx_state == RX_START) begin
            r_rx_bit <= '0;
         end else if (r_rx_state == RX_DATA && w_rx_tick) begin
            r_rx_shift <= {w_rx, r_rx_shift[7:1]};
            r_rx_bit   <= r_rx_bit + 1'b1;
         end
      end
   end

   // ---------------- Command FSM ----------------
   state_t        r_state, w_next;
   logic [1:0]    r_byte_cnt;
   logic          r_is_write;
   logic [31:0]   r_addr, r_wdata;
   logic [CW-1:0] r_req_cmd;
   logic [39:0]   r_reply;
   logic [2:0]    r_left;
   logic          w_last_byte, w_timeout, w_tx_start, w_tx_done;

   assign w_last_byte = r_rx_valid && (r_byte_cnt == 2'd3);

`ifdef UART_UMI_HOST_TIMEOUT_EN
   localparam int TO_CYCLES = TIMEOUT_BITS * BIT_CYCLES;
   localparam int TO_W      = $clog2(TO_CYCLES);
   logic [TO_W-1:0] r_to_cnt;
   logic            w_collecting;

   assign w_collecting = (r_state == S_ADDR) || (r_state == S_DATA);
   assign w_timeout    = w_collecting && !r_rx_valid && (r_to_cnt == TO_W'(TO_CYCLES - 1));

   always_ff @(posedge clk or posedge reset) begin
      if (reset)
         r_to_cnt <= '0;
      else if (w_collecting && !r_rx_valid)
         r_to_cnt <= r_to_cnt + 1'b1;
      else
         r_to_cnt <= '0;
   end
`else
   assign w_timeout = 1'b0;
`endif

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE: if (r_rx_valid)
                    w_next = (r_rx_shift == CH_W || r_rx_shift == CH_R) ? S_ADDR : S_SEND;
         S_ADDR: if (w_last_byte) w_next = r_is_write ? S_DATA : S_REQ;
                 else if (w_timeout) w_next = S_SEND;
         S_DATA: if (w_last_byte) w_next = S_REQ;
                 else if (w_timeout) w_next = S_SEND;
         S_REQ:  if (umi_req_ready) w_next = S_WAIT;
         S_WAIT: if (umi_resp_valid) w_next = S_SEND;
         S_SEND: if (w_tx_done && r_left == 3'd0) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_byte_cnt <= '0;
         r_is_write <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_req_cmd  <= '0;
         r_reply    <= '0;
         r_left     <= '0;
      end else begin
         case (r_state)
            S_IDLE: if (r_rx_valid) begin
               r_byte_cnt <= '0;
               r_addr     <= '0;
               r_wdata    <= '0;
               r_is_write <= (r_rx_shift == CH_W);
               if (r_rx_shift == CH_W) begin
                  r_req_cmd <= CMD_WR;
               end else if (r_rx_shift == CH_R) begin
                  r_req_cmd <= CMD_RD;
               end else begin
                  r_reply <= {32'd0, 8'h3F};
                  r_left  <= 3'd1;
               end
            end
            S_ADDR: if (r_rx_valid) begin
               r_addr[{r_byte_cnt, 3'b000} +: 8] <= r_rx_shift;
               r_byte_cnt <= r_byte_cnt + 1'b1;
            end else if (w_timeout) begin
               r_reply <= {32'd0, 8'h54};
               r_left  <= 3'd1;
            end
            S_DATA: if (r_rx_valid) begin
               r_wdata[{r_byte_cnt, 3'b000} +: 8] <= r_rx_shift;
               r_byte_cnt <= r_byte_cnt + 1'b1;
            end else if (w_timeout) begin
               r_reply <= {32'd0, 8'h54};
               r_left  <= 3'd1;
            end
            S_WAIT: if (umi_resp_valid) begin
               case (umi_resp_cmd[4:0])
                  5'h02: begin r_reply <= {umi_resp_data[31:0], 8'h72}; r_left <= 3'd5; end
                  5'h04: begin r_reply <= {32'd0, 8'h77};               r_left <= 3'd1; end
                  default: begin r_reply <= {32'd0, 8'h21};             r_left <= 3'd1; end
               endcase
            end
            S_SEND: if (w_tx_start) begin
               r_reply <= r_reply >> 8;
               r_left  <= r_left - 1'b1;
            end
            default: ;
         endcase
      end
   end

   // ---------------- UART transmitter ----------------
   logic             r_tx_busy;
   logic [9:0]       r_tx_shift;
   logic [3:0]       r_tx_bit;
   logic [CNT_W-1:0] r_tx_cnt;

   assign w_tx_done  = r_tx_busy && (r_tx_cnt == BIT_LAST) && (r_tx_bit == 4'd9);
   // Loading on the done cycle makes the next start bit follow the stop bit with no gap.
   assign w_tx_start = (r_state == S_SEND) && (r_left != 3'd0) && (!r_tx_busy || w_tx_done);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_tx_busy  <= 1'b0;
         r_tx_shift <= '1;
         r_tx_bit   <= '0;
         r_tx_cnt   <= '0;
      end else if (w_tx_start) begin
         r_tx_busy  <= 1'b1;
         r_tx_shift <= {1'b1, r_reply[7:0], 1'b0};
         r_tx_bit   <= '0;
         r_tx_cnt   <= '0;
      end else if (r_tx_busy) begin
         if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt   <= '0;
            r_tx_shift <= {1'b1, r_tx_shift[9:1]};
            r_tx_bit   <= r_tx_bit + 1'b1;
            if (r_tx_bit == 4'd9) r_tx_busy <= 1'b0;
         end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
         end
      end
   end

   // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
   // valid/ready here come only from r_state, so neither depends on the other side combinationally.
   assign tx_pad          = r_tx_shift[0];
   assign umi_req_valid   = (r_state == S_REQ);
   assign umi_resp_ready  = (r_state == S_WAIT);
   assign umi_req_cmd     = r_req_cmd;
   assign umi_req_dstaddr = AW'(r_addr);
   assign umi_req_srcaddr = SRCADDR;
   assign umi_req_data    = DW'(r_wdata);
   assign o_dbg_state     = r_state;

   logic w_unused;
   assign w_unused = ^{umi_resp_cmd[CW-1:5], umi_resp_data[DW-1:32], umi_resp_dstaddr, umi_resp_srcaddr};

endmodule
